// File: rtl/conway_neighbor_streamer.sv
// conway_neighbor_streamer
//   Scans a WIDTH x HEIGHT Life board held one row per word in an external
//   synchronous-read memory. Keeps a three-row window (above/cur/below) and
//   streams one {state, neighbors} beat per cell in raster order over a
//   valid/ready handshake. Cells off the board read as dead; no wrap-around.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   start             begin a scan (only looked at while idle)
//   busy, done        scan in progress / one-cycle completion pulse
//   row_rd_en/addr    read strobe and row index to the board memory
//   row_rd_data       row word, valid the cycle after row_rd_en; bit x = column x
//   out_valid/ready   beat handshake
//   out_state_0       state of cell (out_x, out_y)
//   out_neighbors     b0 NW, b1 N, b2 NE, b3 W, b4 E, b5 SW, b6 S, b7 SE
//   out_x, out_y      beat coordinates
//   out_last          beat is the bottom-right cell
module conway_neighbor_streamer #(
    parameter  int WIDTH  = 16,
    parameter  int HEIGHT = 16,
    parameter  int ROW_AW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
    localparam int XW     = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              row_rd_en,
    output logic [ROW_AW-1:0] row_rd_addr,
    input  logic [WIDTH-1:0]  row_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_state_0,
    output logic [7:0]        out_neighbors,
    output logic [XW-1:0]     out_x,
    output logic [ROW_AW-1:0] out_y,
    output logic              out_last
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_CAP, S_STREAM, S_DONE
    } state_e;

    localparam logic [XW-1:0]     X_LAST = XW'(WIDTH - 1);
    localparam logic [ROW_AW-1:0] Y_LAST = ROW_AW'(HEIGHT - 1);

    state_e            state_q;
    logic [WIDTH-1:0]  above_q, cur_q, below_q;
    logic [XW-1:0]     x_q;
    logic [ROW_AW-1:0] y_q;
    logic              tgt_below_q;   // 0: pending fetch lands in cur, 1: in below
    logic              busy_q, done_q, rd_en_q, valid_q;
    logic [ROW_AW-1:0] rd_addr_q;

    // Each window row is padded with a dead column on both sides; shifting
    // right by x leaves columns x-1, x, x+1 in bits 0, 1, 2.
    logic [2:0] win_a, win_c, win_b;
    assign win_a = 3'({1'b0, above_q, 1'b0} >> x_q);
    assign win_c = 3'({1'b0, cur_q,   1'b0} >> x_q);
    assign win_b = 3'({1'b0, below_q, 1'b0} >> x_q);

    assign out_neighbors = {win_b[2], win_b[1], win_b[0],
                            win_c[2], win_c[0],
                            win_a[2], win_a[1], win_a[0]};
    assign out_state_0   = win_c[1];
    assign out_x         = x_q;
    assign out_y         = y_q;
    assign out_last      = valid_q && (x_q == X_LAST) && (y_q == Y_LAST);
    assign out_valid     = valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign row_rd_en     = rd_en_q;
    assign row_rd_addr   = rd_addr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            above_q     <= '0;
            cur_q       <= '0;
            below_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            tgt_below_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            valid_q     <= 1'b0;
            rd_addr_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        above_q     <= '0;
                        x_q         <= '0;
                        y_q         <= '0;
                        tgt_below_q <= 1'b0;
                        rd_en_q     <= 1'b1;
                        rd_addr_q   <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= S_REQ;
                    end
                end
                S_REQ: begin
                    rd_en_q <= 1'b0;
                    state_q <= S_CAP;
                end
                S_CAP: begin
                    if (!tgt_below_q) begin
                        cur_q <= row_rd_data;
                        if (HEIGHT > 1) begin
                            tgt_below_q <= 1'b1;
                            rd_en_q     <= 1'b1;
                            rd_addr_q   <= ROW_AW'(1);
                            state_q     <= S_REQ;
                        end else begin
                            below_q <= '0;
                            valid_q <= 1'b1;
                            state_q <= S_STREAM;
                        end
                    end else begin
                        below_q <= row_rd_data;
                        valid_q <= 1'b1;
                        state_q <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (out_ready) begin
                        if (x_q == X_LAST) begin
                            if (y_q == Y_LAST) begin
                                valid_q <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end else begin
                                above_q <= cur_q;
                                cur_q   <= below_q;
                                y_q     <= y_q + 1'b1;
                                x_q     <= '0;
                                // New below row is y+2 relative to the old row;
                                // past the bottom edge it is simply dead.
                                if ((32'(y_q) + 32'd2) < 32'(HEIGHT)) begin
                                    tgt_below_q <= 1'b1;
                                    rd_en_q     <= 1'b1;
                                    rd_addr_q   <= y_q + ROW_AW'(2);
                                    valid_q     <= 1'b0;
                                    state_q     <= S_REQ;
                                end else begin
                                    below_q <= '0;
                                end
                            end
                        end else begin
                            x_q <= x_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conway_neighbor_streamer.sv
// Directed bench for conway_neighbor_streamer: 4x4, 5x5 and 3x1 builds.
module tb_conway_neighbor_streamer;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;
    int   n_tests = 0, n_fail = 0;
    int   cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- 4x4 instance ----------------
    logic       startA, busyA, doneA, renA, readyA, validA, stA, lastA;
    logic [1:0] raddrA, xA, yA;
    logic [3:0] rdA;
    logic [7:0] nbA;
    logic [3:0] memA [4];
    always @(posedge clk) if (renA) rdA <= memA[raddrA];

    conway_neighbor_streamer #(.WIDTH(4), .HEIGHT(4)) dutA (
        .clk(clk), .rst(rst), .start(startA), .busy(busyA), .done(doneA),
        .row_rd_en(renA), .row_rd_addr(raddrA), .row_rd_data(rdA),
        .out_valid(validA), .out_ready(readyA), .out_state_0(stA),
        .out_neighbors(nbA), .out_x(xA), .out_y(yA), .out_last(lastA));

    int          bA, orderA, lastA_cnt, lastA_idx, stallA, doneA_cnt, doneA_cyc, lastA_cyc, rdcntA;
    logic [31:0] rdseqA, firstA_xy;
    logic [7:0]  nbA_m [16];
    logic        stA_m [16];
    logic        pstallA;
    logic [13:0] snapA;

    always @(negedge clk) if (rst) begin
        if (renA) begin rdseqA = (rdseqA << 4) | 32'(raddrA); rdcntA++; end
        if (doneA) begin doneA_cnt++; doneA_cyc = cyc; end
        if (pstallA && {validA, stA, nbA, xA, yA, lastA} !== {1'b1, snapA}) stallA++;
        pstallA = validA && !readyA;
        snapA   = {stA, nbA, xA, yA, lastA};
        if (validA && readyA) begin
            if (bA == 0) firstA_xy = 32'({xA, yA});
            if (int'(xA) != bA % 4 || int'(yA) != bA / 4) orderA++;
            if (lastA) begin lastA_cnt++; lastA_idx = bA; lastA_cyc = cyc; end
            nbA_m[int'(yA) * 4 + int'(xA)] = nbA;
            stA_m[int'(yA) * 4 + int'(xA)] = stA;
            bA++;
        end
    end

    // ---------------- 5x5 instance ----------------
    logic       startB, busyB, doneB, renB, readyB, validB, stB, lastB;
    logic [2:0] raddrB, xB, yB;
    logic [4:0] rdB;
    logic [7:0] nbB;
    logic [4:0] memB [5];
    always @(posedge clk) if (renB) rdB <= memB[raddrB];

    conway_neighbor_streamer #(.WIDTH(5), .HEIGHT(5)) dutB (
        .clk(clk), .rst(rst), .start(startB), .busy(busyB), .done(doneB),
        .row_rd_en(renB), .row_rd_addr(raddrB), .row_rd_data(rdB),
        .out_valid(validB), .out_ready(readyB), .out_state_0(stB),
        .out_neighbors(nbB), .out_x(xB), .out_y(yB), .out_last(lastB));

    int          bB, doneB_cnt, rdcntB, lastB_cnt;
    logic [31:0] rdseqB;
    logic [7:0]  nbB_m [25];
    logic        stB_m [25];

    always @(negedge clk) if (rst) begin
        if (renB) begin rdseqB = (rdseqB << 4) | 32'(raddrB); rdcntB++; end
        if (doneB) doneB_cnt++;
        if (validB && readyB) begin
            nbB_m[int'(yB) * 5 + int'(xB)] = nbB;
            stB_m[int'(yB) * 5 + int'(xB)] = stB;
            if (lastB) lastB_cnt++;
            bB++;
        end
    end

    // ---------------- 3x1 instance ----------------
    logic       startC, busyC, doneC, renC, readyC, validC, stC, lastC;
    logic [0:0] raddrC, yC;
    logic [1:0] xC;
    logic [2:0] rdC, memC;
    logic [7:0] nbC;
    always @(posedge clk) if (renC) rdC <= memC;

    conway_neighbor_streamer #(.WIDTH(3), .HEIGHT(1)) dutC (
        .clk(clk), .rst(rst), .start(startC), .busy(busyC), .done(doneC),
        .row_rd_en(renC), .row_rd_addr(raddrC), .row_rd_data(rdC),
        .out_valid(validC), .out_ready(readyC), .out_state_0(stC),
        .out_neighbors(nbC), .out_x(xC), .out_y(yC), .out_last(lastC));

    int          bC, doneC_cnt, rdcntC, orderC;
    logic [31:0] rdseqC;
    logic [7:0]  nbC_m [3];
    logic        stC_m [3];

    always @(negedge clk) if (rst) begin
        if (renC) begin rdseqC = (rdseqC << 4) | 32'(raddrC); rdcntC++; end
        if (doneC) doneC_cnt++;
        if (validC && readyC) begin
            if (int'(xC) != bC || yC != 1'b0) orderC++;
            nbC_m[int'(xC) % 3] = nbC;
            stC_m[int'(xC) % 3] = stC;
            bC++;
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clrA();
        bA = 0; orderA = 0; lastA_cnt = 0; lastA_idx = -1; stallA = 0;
        doneA_cnt = 0; doneA_cyc = 0; lastA_cyc = 0; rdcntA = 0;
        rdseqA = '0; firstA_xy = 32'hFFFF; pstallA = 1'b0; snapA = '0;
        for (int i = 0; i < 16; i++) begin nbA_m[i] = 8'h5A; stA_m[i] = 1'b0; end
    endtask

    // Start a 4x4 scan, measure start-to-valid latency, run to done.
    task automatic runA(input bit rnd, output int lat, output bit ok);
        clrA();
        startA = 1'b1; step(); startA = 1'b0;
        lat = 1;
        while (!validA && lat < 50) begin step(); lat++; end
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            if (rnd) readyA = ((i % 13) < 5) ? 1'b0 : 1'($urandom_range(0, 1));
            step();
            ok = (doneA_cnt > 0);
        end
        readyA = 1'b1;
    endtask

    int lat;
    bit ok;
    bit pulsed;
    logic [7:0] nb_or;

    initial begin
        rst = 1'b0;
        startA = 1'b0; startB = 1'b0; startC = 1'b0;
        readyA = 1'b1; readyB = 1'b1; readyC = 1'b1;
        rdA = '0; rdB = '0; rdC = '0;
        for (int i = 0; i < 4; i++) memA[i] = 4'h0;
        for (int i = 0; i < 5; i++) memB[i] = 5'h0;
        memC = 3'b101;
        bB = 0; doneB_cnt = 0; rdcntB = 0; rdseqB = '0; lastB_cnt = 0;
        bC = 0; doneC_cnt = 0; rdcntC = 0; rdseqC = '0; orderC = 0;
        for (int i = 0; i < 25; i++) begin nbB_m[i] = 8'h5A; stB_m[i] = 1'b0; end
        for (int i = 0; i < 3; i++) begin nbC_m[i] = 8'h5A; stC_m[i] = 1'b0; end
        clrA();
        step(); step();

        // Reset state
        chk("rst_busy",  32'(busyA),  0);
        chk("rst_valid", 32'(validA), 0);
        chk("rst_rden",  32'(renA),   0);
        chk("rst_done",  32'(doneA),  0);
        chk("rst_nbr",   32'(nbA),    0);
        chk("rst_xy",    32'({xA, yA, lastA}), 0);
        rst = 1'b1;
        step();

        // 4x4 all-zero board
        runA(1'b0, lat, ok);
        chk("A0_finish",  32'(ok), 1);
        chk("A0_latency", 32'(lat), 5);
        chk("A0_busy_after_done", 32'(busyA), 0);
        chk("A0_beats",   32'(bA), 16);
        nb_or = 8'h00;
        for (int i = 0; i < 16; i++) nb_or = nb_or | nbA_m[i];
        chk("A0_nbr_or",  32'(nb_or), 0);
        chk("A0_rd_addrs", rdseqA, 32'h0123);
        chk("A0_rd_count", 32'(rdcntA), 4);
        chk("A0_done_gap", 32'(doneA_cyc - lastA_cyc), 1);
        step(); step();
        chk("A0_done_pulses", 32'(doneA_cnt), 1);

        // 4x4 all-ones board
        for (int i = 0; i < 4; i++) memA[i] = 4'hF;
        runA(1'b0, lat, ok);
        chk("A1_finish",  32'(ok), 1);
        chk("A1_nbr_00",  32'(nbA_m[0]),  32'hD0);
        chk("A1_nbr_33",  32'(nbA_m[15]), 32'h0B);
        chk("A1_nbr_11",  32'(nbA_m[5]),  32'hFF);
        chk("A1_last_cnt", 32'(lastA_cnt), 1);
        chk("A1_last_idx", 32'(lastA_idx), 15);

        // Random ready with 5-cycle low holds; rows 9,6,3,C
        memA[0] = 4'h9; memA[1] = 4'h6; memA[2] = 4'h3; memA[3] = 4'hC;
        runA(1'b1, lat, ok);
        chk("A2_finish",  32'(ok), 1);
        chk("A2_stall_stable", 32'(stallA), 0);
        chk("A2_raster",  32'(orderA), 0);
        chk("A2_beats",   32'(bA), 16);
        chk("A2_nbr_11",  32'(nbA_m[5]), 32'h71);
        chk("A2_st_11",   32'(stA_m[5]), 1);
        chk("A2_rd_addrs", rdseqA, 32'h0123);

        // Reset asserted at beat (x=2, y=1), then rescan
        clrA();
        readyA = 1'b1;
        startA = 1'b1; step(); startA = 1'b0;
        for (int k = 0; k < 100 && !(validA && xA == 2'd2 && yA == 2'd1); k++) step();
        chk("A3_reach_21", 32'(validA && xA == 2'd2 && yA == 2'd1), 1);
        rst = 1'b0; #1;
        chk("A3_rst_valid", 32'(validA), 0);
        chk("A3_rst_busy",  32'(busyA),  0);
        chk("A3_rst_rden",  32'(renA),   0);
        step(); rst = 1'b1; step();
        runA(1'b0, lat, ok);
        chk("A3_finish",  32'(ok), 1);
        chk("A3_first_xy", firstA_xy, 0);
        chk("A3_raster",  32'(orderA), 0);
        chk("A3_beats",   32'(bA), 16);

        // 5x5 blinker (row 2, cols 1..3) with a stray start mid-scan
        memB[2] = 5'b01110;
        startB = 1'b1; step(); startB = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            startB = (i == 12);
            step();
            ok = (doneB_cnt > 0);
        end
        startB = 1'b0;
        step(); step(); step();
        chk("B_finish",  32'(ok), 1);
        chk("B_beats",   32'(bB), 25);
        chk("B_st_x2y2", 32'(stB_m[12]), 1);
        chk("B_nb_x2y2", 32'(nbB_m[12]), 32'h18);
        chk("B_st_x2y1", 32'(stB_m[7]),  0);
        chk("B_nb_x2y1", 32'(nbB_m[7]),  32'hE0);
        chk("B_nb_x0y2", 32'(nbB_m[10]), 32'h10);
        chk("B_rd_addrs", rdseqB, 32'h01234);
        chk("B_rd_count", 32'(rdcntB), 5);
        chk("B_done_cnt", 32'(doneB_cnt), 1);
        chk("B_last_cnt", 32'(lastB_cnt), 1);
        chk("B_idle",     32'(busyB), 0);

        // 3x1 board 101: single read, 3 beats; start during DONE is ignored
        startC = 1'b1; step(); startC = 1'b0;
        lat = 1;
        while (!validC && lat < 50) begin step(); lat++; end
        chk("C_latency", 32'(lat), 3);
        pulsed = 1'b0;
        for (int i = 0; i < 200 && !pulsed; i++) begin
            step();
            if (doneC) begin startC = 1'b1; pulsed = 1'b1; end
        end
        step(); startC = 1'b0;
        step(); step(); step();
        chk("C_saw_done",  32'(pulsed), 1);
        chk("C_beats",     32'(bC), 3);
        chk("C_raster",    32'(orderC), 0);
        chk("C_nb_x1",     32'(nbC_m[1]), 32'h18);
        chk("C_st_x1",     32'(stC_m[1]), 0);
        chk("C_nb_x0",     32'(nbC_m[0]), 32'h00);
        chk("C_rd_count",  32'(rdcntC), 1);
        chk("C_rd_addr",   rdseqC, 0);
        chk("C_done_cnt",  32'(doneC_cnt), 1);
        chk("C_no_restart", 32'(busyC), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
